// File: rtl/m_disp_pkg.sv
// rtl/m_disp_pkg.sv - shared constants and state encodings for the scrolling display
package m_disp_pkg;

    localparam logic [7:0] SEG_BLANK       = 8'hFF;
    localparam int         REFRESH_DIV_DEF = 50000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_LOAD = 2'd2
    } scroll_state_e;

endpackage

// File: rtl/m_digit_mux.sv
// rtl/m_digit_mux.sv - digit time-multiplexer for an active-low 7-segment display
// Ports: clk, rst_n (async active-low); buf_i = per-digit segment patterns (index 0 = rightmost);
//        seg = registered active-low segment drive; an = registered active-low digit enables.
module m_digit_mux
    import m_disp_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIGITS-1:0][7:0] buf_i,
    output logic [7:0]             seg,
    output logic [DIGITS-1:0]      an
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        // Outputs follow the current index, so a new slot shows one clk after idx moves.
        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = buf_i[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: rtl/m_scroll_disp.sv
// rtl/m_scroll_disp.sv - scrolls ROM segment patterns right-to-left across a multiplexed display
// Ports: clk, rst_n (async active-low); step = advance pulse; run = scroll enable;
//        restart = blank and rewind; rom_adr/rom_dat = registered-address message ROM;
//        seg/an = active-low display drive.
module m_scroll_disp
    import m_disp_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int ADR_W       = 4,
    parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              run,
    input  logic              restart,
    output logic [ADR_W-1:0]  rom_adr,
    input  logic [7:0]        rom_dat,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an
);

    scroll_state_e            state_q, state_d;
    logic [ADR_W-1:0]         rom_adr_q, rom_adr_d;
    logic [DIGITS-1:0][7:0]   disp_buf_q, disp_buf_d;

    always_comb begin
        state_d    = state_q;
        rom_adr_d  = rom_adr_q;
        disp_buf_d = disp_buf_q;
        case (state_q)
            S_IDLE: if (step && run) state_d = S_WAIT;
            // rom_dat lags rom_adr by one clk; this cycle lets it settle.
            S_WAIT: state_d = S_LOAD;
            S_LOAD: begin
                for (int i = DIGITS - 1; i > 0; i--) begin
                    disp_buf_d[i] = disp_buf_q[i-1];
                end
                disp_buf_d[0] = rom_dat;
                rom_adr_d     = rom_adr_q + ADR_W'(1);
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // restart wins over any step or load in flight.
        if (restart) begin
            state_d    = S_IDLE;
            rom_adr_d  = '0;
            disp_buf_d = {DIGITS{SEG_BLANK}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rom_adr_q  <= '0;
            disp_buf_q <= {DIGITS{SEG_BLANK}};
        end else begin
            state_q    <= state_d;
            rom_adr_q  <= rom_adr_d;
            disp_buf_q <= disp_buf_d;
        end
    end

    assign rom_adr = rom_adr_q;

    m_digit_mux #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_digit_mux (
        .clk   (clk),
        .rst_n (rst_n),
        .buf_i (disp_buf_q),
        .seg   (seg),
        .an    (an)
    );

endmodule

// File: tb/tb_m_scroll_disp.sv
// tb/tb_m_scroll_disp.sv - self-checking bench for m_scroll_disp with a HELLO message ROM
module tb_m_scroll_disp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step = 1'b0;
    logic       run = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] rom_adr;
    logic [7:0] rom_dat = 8'hFF;
    logic [7:0] seg;
    logic [3:0] an;

    logic [7:0] rom [16];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        step;
        logic        run;
        logic        restart;
        logic [3:0]  exp_adr;
        logic [31:0] exp_buf;
    } vec_t;

    vec_t vecs[$];

    m_scroll_disp #(
        .DIGITS      (4),
        .ADR_W       (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (step),
        .run     (run),
        .restart (restart),
        .rom_adr (rom_adr),
        .rom_dat (rom_dat),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_dat <= rom[rom_adr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        run     = v.run;
        step    = v.step;
        restart = v.restart;
        tick();
        step    = 1'b0;
        restart = 1'b0;
        repeat (7) tick();
        chk($sformatf("vec%0d_adr", idx), 32'(rom_adr), 32'(v.exp_adr));
        chk($sformatf("vec%0d_buf", idx), dut.disp_buf_q, v.exp_buf);
    endtask

    initial begin
        logic [31:0] mb;
        logic [3:0]  exp_an;
        int          guard;

        for (int i = 0; i < 16; i++) rom[i] = 8'hFF;
        rom[0] = 8'h89; rom[1] = 8'h86; rom[2] = 8'hC7; rom[3] = 8'hC7; rom[4] = 8'hC0;

        // step, run, restart, exp_adr, exp_buf
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 32'hFFFFFF89});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd2, 32'hFFFF8986});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd3, 32'hFF8986C7});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd4, 32'h8986C7C7});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd5, 32'h86C7C7C0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd6, 32'hC7C7C0FF});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd7, 32'hC7C0FFFF});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd8, 32'hC0FFFFFF});
        for (int a = 9; a < 16; a++) vecs.push_back('{1'b1, 1'b1, 1'b0, 4'(a), 32'hFFFFFFFF});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 32'hFFFFFFFF});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 32'hFFFFFF89});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd1, 32'hFFFFFF89});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd1, 32'hFFFFFF89});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd1, 32'hFFFFFF89});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd2, 32'hFFFF8986});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 32'hFFFFFFFF});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 32'hFFFFFF89});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd0, 32'hFFFFFFFF});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 32'hFFFFFF89});

        // Reset state and first anode after release
        repeat (3) tick();
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_adr", 32'(rom_adr), 32'h0);
        chk("rst_buf", dut.disp_buf_q, 32'hFFFFFFFF);
        rst_n = 1'b1;
        #1;
        chk("rel_an_before", 32'(an), 32'hF);
        tick();
        chk("rel_an_after", 32'(an), 32'hE);

        foreach (vecs[i]) apply(vecs[i], i);

        // Latency: step at cycle N -> update at end of N+2; steps in WAIT/LOAD ignored;
        // run dropping in WAIT does not cancel the load.
        run = 1'b1; step = 1'b1;
        tick();
        run = 1'b0;
        chk("lat_wait_adr", 32'(rom_adr), 32'h1);
        tick();
        chk("lat_load_adr", 32'(rom_adr), 32'h1);
        chk("lat_load_buf", dut.disp_buf_q, 32'hFFFFFF89);
        tick();
        step = 1'b0;
        chk("lat_done_adr", 32'(rom_adr), 32'h2);
        chk("lat_done_buf", dut.disp_buf_q, 32'hFFFF8986);
        repeat (8) tick();
        chk("lat_noqueue_adr", 32'(rom_adr), 32'h2);
        chk("lat_noqueue_buf", dut.disp_buf_q, 32'hFFFF8986);

        // restart while in WAIT cancels the load
        run = 1'b1; step = 1'b1;
        tick();
        step = 1'b0; restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_wait_adr", 32'(rom_adr), 32'h0);
        chk("rs_wait_buf", dut.disp_buf_q, 32'hFFFFFFFF);
        repeat (6) tick();
        chk("rs_wait_later_adr", 32'(rom_adr), 32'h0);
        chk("rs_wait_later_buf", dut.disp_buf_q, 32'hFFFFFFFF);

        // Load HELLO's first four characters, then freeze and watch the multiplexer
        for (int k = 0; k < 4; k++) apply(vecs[k], 100 + k);
        run = 1'b0;
        mb = 32'h8986C7C7;
        guard = 0;
        while (an == 4'b1110 && guard < 50) begin tick(); guard++; end
        guard = 0;
        while (an != 4'b1110 && guard < 50) begin tick(); guard++; end
        chk("mux_sync", 32'(guard < 50), 32'h1);
        for (int k = 0; k < 4; k++) begin
            exp_an = ~(4'b0001 << k);
            chk($sformatf("mux_an%0d_first", k), 32'(an), 32'(exp_an));
            chk($sformatf("mux_seg%0d", k), 32'(seg), 32'(mb[k*8 +: 8]));
            step = 1'b1;
            repeat (3) tick();
            step = 1'b0;
            chk($sformatf("mux_an%0d_last", k), 32'(an), 32'(exp_an));
            tick();
        end
        chk("mux_frozen_adr", 32'(rom_adr), 32'h4);

        // Async reset while in WAIT: immediate reset values, no load afterwards
        run = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", 32'(seg), 32'hFF);
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_adr", 32'(rom_adr), 32'h0);
        chk("arst_buf", dut.disp_buf_q, 32'hFFFFFFFF);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("arst_after_adr", 32'(rom_adr), 32'h0);
        chk("arst_after_buf", dut.disp_buf_q, 32'hFFFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
